// File: rtl/ecc_pkg.sv
// ecc_pkg: shared types, constants and curve helpers for the public-key generation sequencer
package ecc_pkg;
  localparam int MAX_BYTES = 48;
  localparam int SCALAR_W = MAX_BYTES * 8;
  localparam int ADDR_W = 7;
  localparam logic [7:0] PUB_UNCOMPRESSED = 8'h04;
  typedef enum logic [1:0] {CURVE_P256, CURVE_P384, CURVE_K256, CURVE_RSVD} curve_e;
  typedef enum logic [1:0] {OP_INIT, OP_STEP, OP_FINAL} op_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_ZERO, ERR_CURVE} err_e;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_INIT, S_STEP, S_FINAL, S_OUT, S_ERR} state_e;
  function automatic logic [6:0] curve_bytes(input curve_e c);
    return c == CURVE_P384 ? 7'd48 : 7'd32;
  endfunction
endpackage

// File: rtl/ecc_keygen_ctrl_if.sv
// ecc_keygen_ctrl_if: host command, scalar input, engine op, result read and public-key output buses
// slave: the sequencer's view; master: the host/engine/sink view.
interface ecc_keygen_ctrl_if;
  import ecc_pkg::*;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_curve;
  logic in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic op_valid, op_ready, op_bit, op_done;
  logic [1:0] op_code, op_curve;
  logic [ADDR_W-1:0] res_rd_addr;
  logic [7:0] res_rd_data;
  logic out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic busy, err_valid;
  logic [1:0] err_code;
  modport slave (
    input cmd_valid, cmd_curve, in_valid, in_data, in_last, op_ready, op_done, res_rd_data, out_ready,
    output cmd_ready, in_ready, op_valid, op_code, op_bit, op_curve, res_rd_addr, out_valid, out_data,
    out_last, busy, err_valid, err_code
  );
  modport master (
    output cmd_valid, cmd_curve, in_valid, in_data, in_last, op_ready, op_done, res_rd_data, out_ready,
    input cmd_ready, in_ready, op_valid, op_code, op_bit, op_curve, res_rd_addr, out_valid, out_data,
    out_last, busy, err_valid, err_code
  );
endinterface

// File: rtl/ecc_pub_serializer.sv
// ecc_pub_serializer: streams 0x04 || X || Y from the engine result memory with a one-byte prefetch
// start_i loads the header; rd_addr_o/rd_data_i read the result (1-cycle latency);
// out_*_o/out_ready_i form the output stream; done_o pulses when the last byte is taken.
module ecc_pub_serializer import ecc_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [6:0]        size_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [7:0]        out_data_o,
  output logic              out_last_o,
  output logic              done_o
);
  logic active_q, active_d, pend_q, pend_d, pend_last_q, pend_last_d;
  logic ov_q, ov_d, ol_q, ol_d, pv_q, pv_d, pl_q, pl_d;
  logic [7:0] od_q, od_d, pd_q, pd_d;
  logic [6:0] addr_q, addr_d, total;
  logic pop, free, issue;
  always_comb begin
    total = 7'({size_i, 1'b0});
    pop = ov_q && out_ready_i;
    free = !ov_q || pop;
    // a read is only issued when the output and prefetch slots can absorb it
    issue = active_q && addr_q != total && (2'(ov_q) + 2'(pv_q) + 2'(pend_q) - 2'(pop)) < 2'd2;
    active_d = active_q && !(pop && ol_q);
    addr_d = issue ? addr_q + 7'd1 : addr_q;
    pend_d = issue;
    pend_last_d = issue && addr_q == total - 7'd1;
    ov_d = free ? pv_q || pend_q : ov_q;
    od_d = free ? (pv_q ? pd_q : pend_q ? rd_data_i : od_q) : od_q;
    ol_d = free ? (pv_q ? pl_q : pend_q && pend_last_q) : ol_q;
    pv_d = free ? pv_q && pend_q : pv_q || pend_q;
    pd_d = pend_q ? rd_data_i : pd_q;
    pl_d = pend_q ? pend_last_q : pl_q;
    if (start_i) begin
      active_d = 1'b1;
      addr_d = '0;
      pend_d = 1'b0;
      pend_last_d = 1'b0;
      ov_d = 1'b1;
      od_d = PUB_UNCOMPRESSED;
      ol_d = 1'b0;
      pv_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      active_q <= 1'b0;
      addr_q <= '0;
      pend_q <= 1'b0;
      pend_last_q <= 1'b0;
      ov_q <= 1'b0;
      od_q <= '0;
      ol_q <= 1'b0;
      pv_q <= 1'b0;
      pd_q <= '0;
      pl_q <= 1'b0;
    end else begin
      active_q <= active_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
      pend_last_q <= pend_last_d;
      ov_q <= ov_d;
      od_q <= od_d;
      ol_q <= ol_d;
      pv_q <= pv_d;
      pd_q <= pd_d;
      pl_q <= pl_d;
    end
  assign rd_addr_o = addr_q;
  assign out_valid_o = ov_q;
  assign out_data_o = od_q;
  assign out_last_o = ol_q;
  assign done_o = pop && ol_q;
endmodule

// File: rtl/ecc_keygen_ctrl.sv
// ecc_keygen_ctrl: loads a private scalar, drives a constant-time INIT/STEP/FINAL ladder, emits the public key
// clk, rst_n (async active-low); bus.slave carries command, scalar input, engine op,
// result read, public-key output and busy/error status.
module ecc_keygen_ctrl import ecc_pkg::*; (
  input logic clk,
  input logic rst_n,
  ecc_keygen_ctrl_if.slave bus
);
  state_e state_q, state_d;
  curve_e curve_q, curve_d;
  err_e err_q, err_d;
  logic [6:0] size_q, size_d, cnt_q, cnt_d, cnt_inc;
  logic [SCALAR_W-1:0] scalar_q, scalar_d;
  logic [8:0] bit_q, bit_d;
  logic op_valid_q, op_valid_d, wait_q, wait_d;
  logic ser_start, ser_done;
  always_comb begin
    state_d = state_q;
    curve_d = curve_q;
    err_d = err_q;
    size_d = size_q;
    cnt_d = cnt_q;
    scalar_d = scalar_q;
    bit_d = bit_q;
    op_valid_d = op_valid_q;
    wait_d = wait_q;
    cnt_inc = cnt_q == 7'(MAX_BYTES + 1) ? cnt_q : cnt_q + 7'd1;
    unique case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        if (curve_e'(bus.cmd_curve) == CURVE_RSVD) begin
          err_d = ERR_CURVE;
          state_d = S_ERR;
        end else begin
          err_d = ERR_NONE;
          curve_d = curve_e'(bus.cmd_curve);
          size_d = curve_bytes(curve_e'(bus.cmd_curve));
          cnt_d = '0;
          scalar_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: if (bus.in_valid) begin
        scalar_d = {scalar_q[SCALAR_W-9:0], bus.in_data};
        cnt_d = cnt_inc;
        if (bus.in_last) begin
          state_d = cnt_inc == size_q ? S_CHECK : S_ERR;
          err_d = cnt_inc == size_q ? err_q : ERR_LEN;
        end
      end
      S_CHECK: begin
        state_d = |scalar_q ? S_INIT : S_ERR;
        err_d = |scalar_q ? err_q : ERR_ZERO;
      end
      S_INIT, S_STEP, S_FINAL: begin
        if (!op_valid_q && !wait_q) op_valid_d = 1'b1;
        if (op_valid_q && bus.op_ready) begin
          op_valid_d = 1'b0;
          wait_d = 1'b1;
        end
        // op_done only counts while an accepted op is outstanding
        if (wait_q && bus.op_done) begin
          wait_d = 1'b0;
          if (state_q == S_INIT) begin
            state_d = S_STEP;
            bit_d = 9'({size_q, 3'b000} - 10'd1);
          end else if (state_q == S_STEP) begin
            state_d = bit_q == '0 ? S_FINAL : S_STEP;
            bit_d = bit_q == '0 ? bit_q : bit_q - 9'd1;
          end else state_d = S_OUT;
        end
      end
      S_OUT: state_d = ser_done ? S_IDLE : S_OUT;
      S_ERR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_OUT || state_d == S_ERR) scalar_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      curve_q <= CURVE_P256;
      err_q <= ERR_NONE;
      size_q <= '0;
      cnt_q <= '0;
      scalar_q <= '0;
      bit_q <= '0;
      op_valid_q <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      state_q <= state_d;
      curve_q <= curve_d;
      err_q <= err_d;
      size_q <= size_d;
      cnt_q <= cnt_d;
      scalar_q <= scalar_d;
      bit_q <= bit_d;
      op_valid_q <= op_valid_d;
      wait_q <= wait_d;
    end
  assign ser_start = state_q == S_FINAL && state_d == S_OUT;
  ecc_pub_serializer u_ser (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(ser_start),
    .size_i(size_q),
    .rd_addr_o(bus.res_rd_addr),
    .rd_data_i(bus.res_rd_data),
    .out_ready_i(bus.out_ready),
    .out_valid_o(bus.out_valid),
    .out_data_o(bus.out_data),
    .out_last_o(bus.out_last),
    .done_o(ser_done)
  );
  assign bus.cmd_ready = rst_n && state_q == S_IDLE;
  assign bus.in_ready = state_q == S_LOAD;
  assign bus.op_valid = op_valid_q;
  assign bus.op_code = state_q == S_STEP ? OP_STEP : state_q == S_FINAL ? OP_FINAL : OP_INIT;
  assign bus.op_bit = state_q == S_STEP && scalar_q[bit_q];
  assign bus.op_curve = curve_q;
  assign bus.busy = state_q != S_IDLE;
  assign bus.err_valid = state_q == S_ERR;
  assign bus.err_code = err_q;
endmodule

// File: tb/tb_ecc_keygen_ctrl.sv
// tb_ecc_keygen_ctrl: directed and randomized jobs against an engine model and a key-level reference
module tb_ecc_keygen_ctrl;
  localparam logic [255:0] GX = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
  localparam logic [255:0] GY = 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ecc_keygen_ctrl_if bus ();
  ecc_keygen_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // public key as the engine would produce it; the real generator point for k=1 on P-256
  function automatic logic [7:0] pub_byte(input logic [1:0] c, input logic [383:0] k, input int i);
    logic [511:0] g;
    int sz;
    g = {GX, GY};
    sz = c == 2'd1 ? 48 : 32;
    if (c == 2'd0 && k == 384'd1) return g[(63 - i) * 8 +: 8];
    return k[(i % sz) * 8 +: 8] ^ 8'(i * 29 + c * 7 + 1);
  endfunction
  logic [7:0] key [0:63];
  logic [7:0] res_mem [0:127];
  logic [2:0] op_q[$];
  logic [8:0] out_q[$];
  logic [383:0] rec;
  int pend_e = 0, dly = 0;
  bit spur_en = 1'b1, bp_en = 1'b0, stall_op = 1'b0, stall_o = 1'b0;
  logic [1:0] prev_code;
  logic [7:0] prev_od;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_e = 0;
      stall_op = 1'b0;
      bus.op_done = 1'b0;
      bus.op_ready = 1'b0;
    end else begin
      if (stall_op) chk("op_hold", {bus.op_valid, bus.op_code}, {1'b1, prev_code});
      bus.op_done = 1'b0;
      if (pend_e != 0) begin
        if (dly == 0) begin
          bus.op_done = 1'b1;
          pend_e = 0;
        end else dly--;
      end else if (spur_en && $urandom_range(5) == 0) bus.op_done = 1'b1;
      bus.op_ready = $urandom_range(2) != 0;
      if (bus.op_valid && bus.op_ready) begin
        op_q.push_back({bus.op_code, bus.op_bit});
        pend_e = 1;
        dly = $urandom_range(2);
        if (bus.op_code == 2'd0) rec = '0;
        if (bus.op_code == 2'd1) rec = {rec[382:0], bus.op_bit};
        if (bus.op_code == 2'd2)
          for (int i = 0; i < (bus.op_curve == 2'd1 ? 96 : 64); i++) res_mem[i] = pub_byte(bus.op_curve, rec, i);
      end
      stall_op = bus.op_valid && !bus.op_ready;
      prev_code = bus.op_code;
    end
  end
  always @(posedge clk) bus.res_rd_data <= res_mem[bus.res_rd_addr];
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.out_ready = 1'b0;
      stall_o = 1'b0;
    end else begin
      if (stall_o) chk("out_hold", {bus.out_valid, bus.out_data}, {1'b1, prev_od});
      bus.out_ready = bp_en ? 1'($urandom_range(1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) out_q.push_back({bus.out_last, bus.out_data});
      stall_o = bus.out_valid && !bus.out_ready;
      prev_od = bus.out_data;
    end
  end
  int err_n = 0, err_cyc = 0;
  logic [1:0] err_c;
  bit ov_seen = 1'b0, ir_seen = 1'b0;
  always @(negedge clk)
    if (rst_n) begin
      if (bus.err_valid) begin
        err_n++;
        err_c = bus.err_code;
        err_cyc = cyc;
      end
      if (bus.op_valid) ov_seen = 1'b1;
      if (bus.in_ready) ir_seen = 1'b1;
    end
  task automatic start_job(input logic [1:0] c);
    err_n = 0;
    ov_seen = 1'b0;
    ir_seen = 1'b0;
    op_q.delete();
    out_q.delete();
    @(negedge clk);
    chk("idle_ready", {bus.busy, bus.cmd_ready}, 2'b01);
    bus.cmd_valid = 1'b1;
    bus.cmd_curve = c;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic feed(input int n, output int acc, output int last_cyc);
    acc = 0;
    last_cyc = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = key[i];
      bus.in_last = i == n - 1;
      for (int t = 0; t < 50 && !bus.in_ready; t++) @(negedge clk);
      if (bus.in_ready) begin
        acc++;
        last_cyc = cyc;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic wait_idle();
    for (int t = 0; t < 20000 && bus.busy; t++) @(negedge clk);
    chk("idle_timeout", bus.busy, 0);
  endtask
  task automatic run_job(input logic [1:0] c, input int n, input bit bp);
    int sz, acc, lc, exp_err, bad;
    logic [383:0] k;
    logic [2:0] eo;
    logic [8:0] ex;
    sz = c == 2'd1 ? 48 : 32;
    k = '0;
    for (int i = 0; i < n; i++) k = {k[375:0], key[i]};
    exp_err = c == 2'd3 ? 3 : n != sz ? 1 : k == '0 ? 2 : 0;
    bp_en = bp;
    acc = 0;
    lc = 0;
    start_job(c);
    if (c != 2'd3) feed(n, acc, lc);
    wait_idle();
    chk("err_count", err_n, exp_err != 0);
    chk("err_code_hold", bus.err_code, exp_err);
    if (exp_err != 0) begin
      chk("err_pulse_code", err_c, exp_err);
      chk("no_ops", ov_seen, 0);
      if (c == 2'd3) chk("no_in_ready", ir_seen, 0);
      else begin
        chk("beats", acc, n);
        chk("err_latency", err_cyc - lc, exp_err == 1 ? 1 : 2);
      end
    end else begin
      chk("op_count", op_q.size(), sz * 8 + 2);
      bad = 0;
      for (int i = 0; i < op_q.size(); i++) begin
        eo = i == 0 ? 3'b000 : i == sz * 8 + 1 ? 3'b100 : {2'd1, k[sz * 8 - i]};
        if (op_q[i] !== eo) bad++;
      end
      chk("op_seq", bad, 0);
      chk("out_len", out_q.size(), 2 * sz + 1);
      bad = 0;
      for (int i = 0; i < out_q.size(); i++) begin
        ex = {i == 2 * sz, i == 0 ? 8'h04 : pub_byte(c, k, i - 1)};
        if (out_q[i] !== ex) bad++;
      end
      chk("out_bytes", bad, 0);
    end
  endtask
  task automatic rand_key(input int n);
    for (int i = 0; i < n; i++) key[i] = 8'($urandom_range(255));
    key[0] = key[0] | 8'h01;
  endtask
  task automatic chk_all_zero(input string tag);
    chk(tag, {bus.cmd_ready, bus.in_ready, bus.op_valid, bus.op_code, bus.op_bit, bus.op_curve,
              bus.res_rd_addr, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.err_valid,
              bus.err_code}, 0);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_curve = 2'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    bus.in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", {bus.cmd_ready, bus.busy}, 2'b10);
    for (int i = 0; i < 32; i++) key[i] = i == 31 ? 8'h01 : 8'h00;
    run_job(2'd0, 32, 1'b0);
    rand_key(48);
    run_job(2'd1, 48, 1'b1);
    rand_key(33);
    run_job(2'd0, 31, 1'b0);
    run_job(2'd0, 33, 1'b1);
    rand_key(50);
    run_job(2'd1, 50, 1'b0);
    for (int i = 0; i < 32; i++) key[i] = 8'h00;
    run_job(2'd0, 32, 1'b0);
    run_job(2'd3, 0, 1'b0);
    rand_key(32);
    run_job(2'd2, 32, 1'b1);
    begin
      int acc, lc;
      rand_key(32);
      bp_en = 1'b0;
      start_job(2'd0);
      feed(32, acc, lc);
      for (int t = 0; t < 5000 && op_q.size() < 101; t++) @(negedge clk);
      chk("reach_step100", {op_q.size() >= 101, bus.op_code}, {1'b1, 2'd1});
      #2 rst_n = 1'b0;
      #1 chk_all_zero("mid_job_reset");
      @(negedge clk);
      rst_n = 1'b1;
    end
    rand_key(32);
    run_job(2'd0, 32, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
